// File: rtl/add32_seq_arb.sv
// Byte-serial 32-bit adder: two clients share one 8-bit slice via a round-robin arbiter.
// Optional feature: define ADD32_SUB_EN to enable subtraction through op0/op1.
module add32_seq_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    input  logic        cin0,
    input  logic        cin1,
    input  logic        op0,
    input  logic        op1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy,
    output logic        done,
    output logic        done_id,
    output logic [31:0] s,
    output logic        cout
);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] a_r, b_r;
    logic        id_r;
    logic        lp;
    logic [1:0]  beat;
    logic        carry;
    logic [23:0] res;
    logic        any_req, win, grant, last_beat;
    logic [7:0]  a_byte, b_byte, sum_byte;
    logic        slice_c;
    logic        cin_sel;

`ifdef ADD32_SUB_EN
    logic        op_r;
    // Subtract forces the carry to 1 (two's complement) and ignores cin.
    assign cin_sel = (win ? op1 : op0) ? 1'b1 : (win ? cin1 : cin0);
`else
    logic        unused_op;
    assign unused_op = op0 ^ op1;
    assign cin_sel   = win ? cin1 : cin0;
`endif

    // Both requesting: the client that did not win last time gets the slice.
    assign any_req   = req0 | req1;
    assign win       = (req0 && req1) ? ~lp : req1;
    assign last_beat = (beat == 2'd3);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of a combinational block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        unique case (state)
            IDLE: if (any_req) begin
                grant     = 1'b1;
                state_nxt = ADD;
            end
            ADD:  if (last_beat) state_nxt = DONE;
            // DONE doubles as the next arbitration slot to sustain one op per 5 cycles.
            DONE: if (any_req) begin
                grant     = 1'b1;
                state_nxt = ADD;
            end else begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        a_byte = a_r[8*beat +: 8];
        b_byte = b_r[8*beat +: 8];
`ifdef ADD32_SUB_EN
        if (op_r) b_byte = ~b_byte;
`endif
        {slice_c, sum_byte} = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            id_r    <= 1'b0;
            lp      <= 1'b1;
            beat    <= 2'd0;
            carry   <= 1'b0;
            res     <= '0;
            s       <= '0;
            cout    <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
`ifdef ADD32_SUB_EN
            op_r    <= 1'b0;
`endif
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            if (grant) begin
                a_r   <= win ? a1 : a0;
                b_r   <= win ? b1 : b0;
                id_r  <= win;
                lp    <= win;
                gnt0  <= ~win;
                gnt1  <= win;
                beat  <= 2'd0;
                carry <= cin_sel;
`ifdef ADD32_SUB_EN
                op_r  <= win ? op1 : op0;
`endif
            end else if (state == ADD) begin
                carry <= slice_c;
                beat  <= beat + 2'd1;
                case (beat)
                    2'd0:    res[7:0]   <= sum_byte;
                    2'd1:    res[15:8]  <= sum_byte;
                    2'd2:    res[23:16] <= sum_byte;
                    default: begin
                        s       <= {sum_byte, res};
                        cout    <= slice_c;
                        done    <= 1'b1;
                        done_id <= id_r;
                    end
                endcase
            end
        end
    end

endmodule
